eu_iqueue_ooo: RTL and testbench

Out-of-order issue queue for one execution unit: the next generation of the in-order instruction FIFO. It holds dispatched instructions together with two source-operand tags each. It snoops a configurable number of result wakeup buses and issues the oldest entry whose operands are both ready. It sits between dispatch and the execution unit's operand-read stage, with the same valid/ready handshake on both sides as the in-order queue.

---
 rtl/eu_iqueue_ooo_pkg.sv | 26 ++
 rtl/eu_iqueue_ooo_if.sv | 39 +++
 rtl/eu_iqueue_age_select.sv | 24 ++
 rtl/eu_iqueue_ooo.sv | 161 ++++++++++++++++
 tb/tb_eu_iqueue_ooo.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/eu_iqueue_ooo_pkg.sv
// Shared types for the out-of-order issue queue.
// The instruction payload type_iqueue_entry is the same one the in-order
// queue carries; the tag/source types describe the per-entry operand state.
package eu_iqueue_ooo_pkg;

    localparam int IQ_TAG_WIDTH = 6;

    typedef logic [IQ_TAG_WIDTH-1:0] type_reg_tag;

    typedef struct packed {
        type_reg_tag tag;
        logic        rdy;
    } type_iq_src;

    typedef struct packed {
        logic [3:0] opcode;
        logic [5:0] dst_tag;
        logic [5:0] imm;
    } type_iqueue_entry;

    typedef struct packed {
        type_iqueue_entry  payload;
        type_iq_src [1:0]  src;
    } type_iq_ooo_entry;

endpackage

// File: rtl/eu_iqueue_ooo_if.sv
// Dispatch, wakeup and issue handshake bundle of the out-of-order issue queue.
// master: dispatch/EU/result side, slave: the queue itself.
interface eu_iqueue_ooo_if
    import eu_iqueue_ooo_pkg::*;
#(
    parameter int LOG2_QUEUE_LENGTH = 3,
    parameter int NUM_WAKEUP        = 2,
    parameter int TAG_WIDTH         = 6
);
    type_iqueue_entry                         dispatched_instr_i;
    logic [1:0][TAG_WIDTH-1:0]                dispatched_src_tag_i;
    logic [1:0]                               dispatched_src_rdy_i;
    logic                                     dispatched_instr_valid_i;
    logic                                     is_full_o;
    logic [NUM_WAKEUP-1:0][TAG_WIDTH-1:0]     wakeup_tag_i;
    logic [NUM_WAKEUP-1:0]                    wakeup_valid_i;
    type_iqueue_entry                         curr_instr_to_exec_o;
    logic                                     curr_instr_to_exec_valid_o;
    logic                                     ready_for_next_instr_i;
    logic                                     flush_i;
    logic [LOG2_QUEUE_LENGTH:0]               occupancy_o;

    modport master (
        output dispatched_instr_i, dispatched_src_tag_i, dispatched_src_rdy_i,
               dispatched_instr_valid_i, wakeup_tag_i, wakeup_valid_i,
               ready_for_next_instr_i, flush_i,
        input  is_full_o, curr_instr_to_exec_o, curr_instr_to_exec_valid_o,
               occupancy_o
    );

    modport slave (
        input  dispatched_instr_i, dispatched_src_tag_i, dispatched_src_rdy_i,
               dispatched_instr_valid_i, wakeup_tag_i, wakeup_valid_i,
               ready_for_next_instr_i, flush_i,
        output is_full_o, curr_instr_to_exec_o, curr_instr_to_exec_valid_o,
               occupancy_o
    );

endinterface

// File: rtl/eu_iqueue_age_select.sv
// Oldest-first grant: an eligible entry wins when no other eligible entry is
// older than it. age[j][i] = 1 means entry j is older than entry i.
module eu_iqueue_age_select #(
    parameter int N = 8
) (
    input  logic [N-1:0][N-1:0] age,
    input  logic [N-1:0]        eligible,
    output logic [N-1:0]        grant
);

    // Knock out every eligible entry that has an older eligible competitor
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && eligible[j] && age[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/eu_iqueue_ooo.sv
// Out-of-order issue queue for one execution unit.
// Entries wait for both source tags to be woken up by result buses, then the
// oldest ready entry is presented to the EU.
// Build option: EU_IQUEUE_WAKEUP_BYPASS_EN lets same-cycle wakeup matches feed
// eligibility directly (wakeup -> select -> output combinational path).
module eu_iqueue_ooo
    import eu_iqueue_ooo_pkg::*;
#(
    parameter int LOG2_QUEUE_LENGTH = 3,
    parameter int NUM_WAKEUP        = 2,
    parameter int TAG_WIDTH         = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    eu_iqueue_ooo_if.slave bus
);

    localparam int N = 2**LOG2_QUEUE_LENGTH;
    localparam int PW = $bits(type_iqueue_entry);

    logic [N-1:0]               valid_q;
    type_iqueue_entry           payload_q [N];
    logic [1:0][TAG_WIDTH-1:0]  tag_q     [N];
    logic [1:0]                 rdy_q     [N];
    logic [N-1:0][N-1:0]        age_q;
    logic [LOG2_QUEUE_LENGTH:0] occ_q;

    logic [1:0]                 wake_hit  [N];
    logic [1:0]                 disp_hit;
    logic [1:0]                 rdy_eff   [N];
    logic [N-1:0]               eligible;
    logic [N-1:0]               grant;
    logic [N-1:0]               alloc_oh;
    logic [N-1:0]               issue_oh;
    logic [N-1:0]               valid_d;
    logic [LOG2_QUEUE_LENGTH:0] occ_d;
    logic [PW-1:0]              mux_bits;
    logic                       is_full;
    logic                       do_dispatch;
    logic                       do_issue;

    assign is_full     = &valid_q;
    assign do_dispatch = bus.dispatched_instr_valid_i && !is_full && !bus.flush_i;

    // Tag compare of every stored and incoming source against all valid buses
    always_comb begin
        disp_hit = '0;
        for (int i = 0; i < N; i++) begin
            wake_hit[i] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            for (int b = 0; b < NUM_WAKEUP; b++) begin
                if (bus.wakeup_valid_i[b]) begin
                    if (bus.wakeup_tag_i[b] == bus.dispatched_src_tag_i[s]) begin
                        disp_hit[s] = 1'b1;
                    end
                    for (int i = 0; i < N; i++) begin
                        if (bus.wakeup_tag_i[b] == tag_q[i][s]) begin
                            wake_hit[i][s] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Eligibility: valid with both operands ready
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
`ifdef EU_IQUEUE_WAKEUP_BYPASS_EN
            rdy_eff[i] = rdy_q[i] | wake_hit[i];
`else
            rdy_eff[i] = rdy_q[i];
`endif
            eligible[i] = valid_q[i] && (&rdy_eff[i]);
        end
    end

    eu_iqueue_age_select #(
        .N (N)
    ) u_age_select (
        .age      (age_q),
        .eligible (eligible),
        .grant    (grant)
    );

    // One-hot payload mux driven by the grant
    always_comb begin
        mux_bits = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                mux_bits = mux_bits | payload_q[i];
            end
        end
    end

    assign bus.curr_instr_to_exec_o       = type_iqueue_entry'(mux_bits);
    assign bus.curr_instr_to_exec_valid_o = |grant;
    assign bus.is_full_o                  = is_full;
    assign bus.occupancy_o                = occ_q;

    assign do_issue = bus.curr_instr_to_exec_valid_o && bus.ready_for_next_instr_i
                      && !bus.flush_i;
    assign issue_oh = do_issue ? grant : '0;

    // Lowest free slot, next valid vector and its population count
    always_comb begin
        alloc_oh = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_oh    = '0;
                alloc_oh[i] = 1'b1;
            end
        end
        if (!do_dispatch) begin
            alloc_oh = '0;
        end
        valid_d = bus.flush_i ? '0 : ((valid_q & ~issue_oh) | alloc_oh);
        occ_d = '0;
        for (int i = 0; i < N; i++) begin
            occ_d = occ_d + {{LOG2_QUEUE_LENGTH{1'b0}}, valid_d[i]};
        end
    end

    // Entry state, operand readiness and age matrix
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            age_q   <= '0;
            occ_q   <= '0;
            for (int i = 0; i < N; i++) begin
                payload_q[i] <= '0;
                tag_q[i]     <= '0;
                rdy_q[i]     <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < N; i++) begin
                if (valid_q[i]) begin
                    rdy_q[i] <= rdy_q[i] | wake_hit[i];
                end
            end
            for (int k = 0; k < N; k++) begin
                if (alloc_oh[k]) begin
                    payload_q[k] <= bus.dispatched_instr_i;
                    tag_q[k]     <= bus.dispatched_src_tag_i;
                    rdy_q[k]     <= bus.dispatched_src_rdy_i | disp_hit;
                    age_q[k]     <= '0;
                    for (int j = 0; j < N; j++) begin
                        if (j != k) begin
                            age_q[j][k] <= valid_q[j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_eu_iqueue_ooo.sv
// Directed bench for eu_iqueue_ooo: in-order latency, out-of-order issue,
// dispatch-cycle wakeup capture, full queue, flush, async reset and age order.
// Expectations cover both settings of EU_IQUEUE_WAKEUP_BYPASS_EN.
module tb_eu_iqueue_ooo;
    import eu_iqueue_ooo_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    eu_iqueue_ooo_if iq_bus ();

    eu_iqueue_ooo dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (iq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        iq_bus.dispatched_instr_valid_i = 1'b0;
        iq_bus.dispatched_instr_i       = '0;
        iq_bus.dispatched_src_tag_i     = '0;
        iq_bus.dispatched_src_rdy_i     = 2'b00;
        iq_bus.wakeup_valid_i           = '0;
        iq_bus.wakeup_tag_i             = '0;
        iq_bus.flush_i                  = 1'b0;
    endtask

    task automatic drive_disp(input logic [15:0] p, input logic [5:0] t0,
                              input logic [5:0] t1, input logic [1:0] rdy);
        iq_bus.dispatched_instr_valid_i = 1'b1;
        iq_bus.dispatched_instr_i       = type_iqueue_entry'(p);
        iq_bus.dispatched_src_tag_i     = {t1, t0};
        iq_bus.dispatched_src_rdy_i     = rdy;
    endtask

    task automatic check_state(input string tag, input logic vld, input logic [15:0] instr,
                               input logic [3:0] occ, input logic full);
        check_val({tag, "_valid"}, 32'(iq_bus.curr_instr_to_exec_valid_o), 32'(vld));
        if (vld) check_val({tag, "_instr"}, 32'(iq_bus.curr_instr_to_exec_o), 32'(instr));
        check_val({tag, "_occ"},   32'(iq_bus.occupancy_o), 32'(occ));
        check_val({tag, "_full"},  32'(iq_bus.is_full_o), 32'(full));
    endtask

    initial begin
        reset_n = 1'b0;
        set_idle();
        iq_bus.ready_for_next_instr_i = 1'b0;
        #3;
        check_state("reset", 1'b0, 16'h0, 4'd0, 1'b0);
        check_val("reset_instr", 32'(iq_bus.curr_instr_to_exec_o), 32'h0);
        #10 reset_n = 1'b1;

        // back-to-back in-order issue with ready held high
        iq_bus.ready_for_next_instr_i = 1'b1;
        drive_disp(16'h1111, 6'd0, 6'd0, 2'b11);
        tick();
        drive_disp(16'h2222, 6'd0, 6'd0, 2'b11);
        #1 check_state("t1_a", 1'b1, 16'h1111, 4'd1, 1'b0);
        tick();
        set_idle();
        #1 check_state("t1_b", 1'b1, 16'h2222, 4'd1, 1'b0);
        tick();
        #1 check_state("t1_empty", 1'b0, 16'h0, 4'd0, 1'b0);

        // younger ready entry overtakes older blocked one; wakeup on bus 1
        iq_bus.ready_for_next_instr_i = 1'b0;
        drive_disp(16'h00A0, 6'd5, 6'd0, 2'b10);
        tick();
        drive_disp(16'h00B0, 6'd0, 6'd0, 2'b11);
        #1 check_state("t2_a_blocked", 1'b0, 16'h0, 4'd1, 1'b0);
        tick();
        set_idle();
        #1 check_state("t2_b_first", 1'b1, 16'h00B0, 4'd2, 1'b0);
        iq_bus.ready_for_next_instr_i = 1'b1;
        tick();
        iq_bus.wakeup_tag_i   = {6'd5, 6'd5};
        iq_bus.wakeup_valid_i = 2'b10;
`ifdef EU_IQUEUE_WAKEUP_BYPASS_EN
        #1 check_state("t2_wake", 1'b1, 16'h00A0, 4'd1, 1'b0);
        tick();
        set_idle();
        #1 check_state("t2_after", 1'b0, 16'h0, 4'd0, 1'b0);
`else
        #1 check_state("t2_wake", 1'b0, 16'h0, 4'd1, 1'b0);
        tick();
        set_idle();
        #1 check_state("t2_after", 1'b1, 16'h00A0, 4'd1, 1'b0);
`endif
        tick();
        #1 check_state("t2_empty", 1'b0, 16'h0, 4'd0, 1'b0);

        // wakeup coinciding with dispatch is captured
        iq_bus.ready_for_next_instr_i = 1'b0;
        drive_disp(16'h00C0, 6'd9, 6'd3, 2'b10);
        iq_bus.wakeup_tag_i   = {6'd0, 6'd9};
        iq_bus.wakeup_valid_i = 2'b01;
        tick();
        set_idle();
        #1 check_state("t3_captured", 1'b1, 16'h00C0, 4'd1, 1'b0);
        iq_bus.ready_for_next_instr_i = 1'b1;
        tick();
        #1 check_state("t3_empty", 1'b0, 16'h0, 4'd0, 1'b0);

        // fill with blocked entries; dispatch while full and issuing is refused
        iq_bus.ready_for_next_instr_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_disp(16'h0100 + 16'(i), 6'(20 + i), 6'd0, 2'b10);
            tick();
        end
        set_idle();
        #1 check_state("t4_full", 1'b0, 16'h0, 4'd8, 1'b1);
        iq_bus.wakeup_tag_i   = {6'd0, 6'd23};
        iq_bus.wakeup_valid_i = 2'b01;
        tick();
        set_idle();
        drive_disp(16'h0999, 6'd0, 6'd0, 2'b11);
        iq_bus.ready_for_next_instr_i = 1'b1;
        #1 check_state("t4_issue", 1'b1, 16'h0103, 4'd8, 1'b1);
        tick();
        set_idle();
        iq_bus.ready_for_next_instr_i = 1'b0;
        #1 check_state("t4_refused", 1'b0, 16'h0, 4'd7, 1'b0);

        // flush, refill five, then flush with a concurrent dispatch
        iq_bus.flush_i = 1'b1;
        tick();
        set_idle();
        #1 check_state("t5_flush1", 1'b0, 16'h0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_disp(16'h0200 + 16'(i), 6'(40 + i), 6'(50 + i), 2'b00);
            tick();
        end
        set_idle();
        #1 check_state("t5_five", 1'b0, 16'h0, 4'd5, 1'b0);
        drive_disp(16'h0555, 6'd0, 6'd0, 2'b11);
        iq_bus.flush_i = 1'b1;
        iq_bus.ready_for_next_instr_i = 1'b1;
        tick();
        set_idle();
        iq_bus.ready_for_next_instr_i = 1'b0;
        #1 check_state("t5_flush2", 1'b0, 16'h0, 4'd0, 1'b0);

        // asynchronous reset with three entries pending
        for (int i = 0; i < 3; i++) begin
            drive_disp(16'h0300 + 16'(i), 6'd0, 6'd0, 2'b11);
            tick();
        end
        set_idle();
        #1 check_state("t6_three", 1'b1, 16'h0300, 4'd3, 1'b0);
        #1 reset_n = 1'b0;
        #1 check_state("t6_reset", 1'b0, 16'h0, 4'd0, 1'b0);
        check_val("t6_reset_instr", 32'(iq_bus.curr_instr_to_exec_o), 32'h0);
        #3 reset_n = 1'b1;

        // age beats index: older entry in slot 1, younger one reuses slot 0
        drive_disp(16'h0400, 6'd0, 6'd0, 2'b11);
        tick();
        drive_disp(16'h0401, 6'd0, 6'd0, 2'b11);
        #1 check_state("t7_p", 1'b1, 16'h0400, 4'd1, 1'b0);
        tick();
        set_idle();
        iq_bus.ready_for_next_instr_i = 1'b1;
        tick();
        iq_bus.ready_for_next_instr_i = 1'b0;
        drive_disp(16'h0402, 6'd0, 6'd0, 2'b11);
        #1 check_state("t7_q", 1'b1, 16'h0401, 4'd1, 1'b0);
        tick();
        set_idle();
        #1 check_state("t7_q_older", 1'b1, 16'h0401, 4'd2, 1'b0);
        iq_bus.ready_for_next_instr_i = 1'b1;
        tick();
        #1 check_state("t7_r", 1'b1, 16'h0402, 4'd1, 1'b0);
        tick();
        #1 check_state("t7_empty", 1'b0, 16'h0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
